// File: rtl/universal_shift_reg_n_if.sv
// Operation and data bus of the universal shift register. The master side
// issues operations and serial input bits. The slave side is the register.
interface universal_shift_reg_n_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             op_valid;
  logic             op_ready;
  logic [2:0]       mode;
  logic             s_left_din;
  logic             s_right_din;
  logic [WIDTH-1:0] p_din;
  logic [CNT_W-1:0] amt;
  logic             burst_left;
  logic [WIDTH-1:0] p_dout;
  logic             s_left_dout;
  logic             s_right_dout;
  logic             done;

  modport master (
    output op_valid, mode, s_left_din, s_right_din, p_din, amt, burst_left,
    input  op_ready, p_dout, s_left_dout, s_right_dout, done
  );

  modport slave (
    input  op_valid, mode, s_left_din, s_right_din, p_din, amt, burst_left,
    output op_ready, p_dout, s_left_dout, s_right_dout, done
  );
endinterface

// File: rtl/universal_shift_reg_n.sv
// WIDTH-bit universal shift register: hold, shifts, rotates and parallel load
// in one edge, plus an autonomous multi-edge burst shift with a done pulse.
module universal_shift_reg_n #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   clr,
  universal_shift_reg_n_if.slave bus
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  logic [0:0]       state_reg, state_next;
  logic [CNT_W-1:0] remaining_reg, remaining_next;
  logic             dir_left_reg, dir_left_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic             done_reg, done_next;

  logic [WIDTH-2:0] upper_bits;
  logic [WIDTH-1:0] shr_val, shl_val, rotr_val, rotl_val, asr_val, burst_val;
  logic             burst_dir;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_upper
      assign upper_bits[gi] = data_reg[gi+1];
    end
  endgenerate

  assign shr_val  = {bus.s_right_din, upper_bits};
  assign shl_val  = {data_reg[WIDTH-2:0], bus.s_left_din};
  assign rotr_val = {data_reg[0], upper_bits};
  assign rotl_val = {data_reg[WIDTH-2:0], data_reg[WIDTH-1]};
  assign asr_val  = {data_reg[WIDTH-1], upper_bits};

  // Direction is taken live on the accept edge, then held for the rest of the burst.
  assign burst_dir = (state_reg == IDLE) ? bus.burst_left : dir_left_reg;
  assign burst_val = burst_dir ? shl_val : shr_val;

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    dir_left_next  = dir_left_reg;
    data_next      = data_reg;
    done_next      = 1'b0;
    if (state_reg == BURST) begin
      data_next      = burst_val;
      remaining_next = remaining_reg - CNT_W'(1);
      if (remaining_reg == CNT_W'(1)) begin
        state_next = IDLE;
        done_next  = 1'b1;
      end
    end else if (bus.op_valid) begin
      case (bus.mode)
        3'b000: data_next = data_reg;
        3'b001: data_next = shr_val;
        3'b010: data_next = shl_val;
        3'b011: data_next = bus.p_din;
        3'b100: data_next = rotr_val;
        3'b101: data_next = rotl_val;
        3'b110: data_next = asr_val;
        default: begin
          dir_left_next = bus.burst_left;
          if (bus.amt == '0) begin
            done_next = 1'b1;
          end else begin
            data_next = burst_val;
            if (bus.amt == CNT_W'(1)) begin
              done_next = 1'b1;
            end else begin
              remaining_next = bus.amt - CNT_W'(1);
              state_next     = BURST;
            end
          end
        end
      endcase
    end
  end

  // All state moves on the falling edge; clr also aborts a burst without a done pulse.
  always_ff @(negedge clk) begin
    if (clr) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      dir_left_reg  <= 1'b0;
      data_reg      <= '0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      dir_left_reg  <= dir_left_next;
      data_reg      <= data_next;
      done_reg      <= done_next;
    end
  end

  assign bus.op_ready     = (state_reg == IDLE);
  assign bus.p_dout       = data_reg;
  assign bus.s_left_dout  = data_reg[WIDTH-1];
  assign bus.s_right_dout = data_reg[0];
  assign bus.done         = done_reg;
endmodule

// File: tb/tb_universal_shift_reg_n.sv
// Bench for universal_shift_reg_n: directed vector table followed by a random
// run checked against an arithmetic model of the register.
module tb_universal_shift_reg_n;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  universal_shift_reg_n_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus_if ();

  universal_shift_reg_n #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus_if)
  );

  typedef struct {
    logic       clr;
    logic       valid;
    logic [2:0] mode;
    logic       sl;
    logic       sr;
    logic [7:0] pdin;
    logic [3:0] amt;
    logic       bl;
    logic [7:0] exp_p;
    logic       exp_ready;
    logic       exp_done;
  } vec_t;

  vec_t vecs[$];
  int n_vec  = 0;
  int n_miss = 0;

  // Model: register value as an integer, shifts still owed, latched direction.
  int m_p     = 0;
  int m_pend  = 0;
  int m_left  = 0;
  int m_done  = 0;

  function automatic int do_shift(int p, int left, int sl, int sr);
    if (left != 0) return (p * 2 + sl) % 256;
    return p / 2 + sr * 128;
  endfunction

  task automatic model_edge(input vec_t v);
    m_done = 0;
    if (v.clr) begin
      m_p = 0; m_pend = 0;
    end else if (m_pend > 0) begin
      m_p = do_shift(m_p, m_left, int'(v.sl), int'(v.sr));
      m_pend--;
      if (m_pend == 0) m_done = 1;
    end else if (v.valid) begin
      case (int'(v.mode))
        1: m_p = m_p / 2 + int'(v.sr) * 128;
        2: m_p = (m_p * 2 + int'(v.sl)) % 256;
        3: m_p = int'(v.pdin);
        4: m_p = m_p / 2 + (m_p % 2) * 128;
        5: m_p = (m_p * 2) % 256 + m_p / 128;
        6: m_p = m_p / 2 + ((m_p >= 128) ? 128 : 0);
        7: begin
          m_left = int'(v.bl);
          if (v.amt == 0) m_done = 1;
          else begin
            m_p = do_shift(m_p, m_left, int'(v.sl), int'(v.sr));
            m_pend = int'(v.amt) - 1;
            if (m_pend == 0) m_done = 1;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Drive one edge of stimulus, then sample on the following rising edge.
  task automatic apply(input vec_t v);
    clr                = v.clr;
    bus_if.op_valid    = v.valid;
    bus_if.mode        = v.mode;
    bus_if.s_left_din  = v.sl;
    bus_if.s_right_din = v.sr;
    bus_if.p_din       = v.pdin;
    bus_if.amt         = v.amt;
    bus_if.burst_left  = v.bl;
    @(negedge clk);
    model_edge(v);
    @(posedge clk);
  endtask

  function automatic vec_t mk(logic c, logic va, logic [2:0] mo, logic sl, logic sr,
                              logic [7:0] pd, logic [3:0] am, logic bl,
                              logic [7:0] ep, logic er, logic ed);
    vec_t v;
    v.clr = c; v.valid = va; v.mode = mo; v.sl = sl; v.sr = sr; v.pdin = pd;
    v.amt = am; v.bl = bl; v.exp_p = ep; v.exp_ready = er; v.exp_done = ed;
    return v;
  endfunction

  initial begin
    vec_t v;
    logic [7:0] ep;
    clr = 1'b0;
    bus_if.op_valid = 1'b0; bus_if.mode = 3'd0; bus_if.s_left_din = 1'b0;
    bus_if.s_right_din = 1'b0; bus_if.p_din = 8'h00; bus_if.amt = 4'd0;
    bus_if.burst_left = 1'b0;

    vecs.push_back(mk(1, 0, 3'd0, 0, 0, 8'h00, 4'd0, 0, 8'h00, 1, 0));
    vecs.push_back(mk(1, 0, 3'd0, 0, 0, 8'h00, 4'd0, 0, 8'h00, 1, 0));
    vecs.push_back(mk(0, 1, 3'd3, 0, 0, 8'hA5, 4'd0, 0, 8'hA5, 1, 0));
    vecs.push_back(mk(0, 1, 3'd1, 0, 1, 8'h00, 4'd0, 0, 8'hD2, 1, 0));
    vecs.push_back(mk(0, 1, 3'd3, 0, 0, 8'hA5, 4'd0, 0, 8'hA5, 1, 0));
    vecs.push_back(mk(0, 1, 3'd4, 0, 0, 8'h00, 4'd0, 0, 8'hD2, 1, 0));
    vecs.push_back(mk(0, 1, 3'd5, 0, 0, 8'h00, 4'd0, 0, 8'hA5, 1, 0));
    vecs.push_back(mk(0, 1, 3'd2, 0, 0, 8'h00, 4'd0, 0, 8'h4A, 1, 0));
    vecs.push_back(mk(0, 1, 3'd3, 0, 0, 8'h85, 4'd0, 0, 8'h85, 1, 0));
    vecs.push_back(mk(0, 1, 3'd6, 0, 0, 8'h00, 4'd0, 0, 8'hC2, 1, 0));
    vecs.push_back(mk(0, 0, 3'd3, 0, 0, 8'hFF, 4'd0, 0, 8'hC2, 1, 0));
    vecs.push_back(mk(0, 1, 3'd3, 0, 0, 8'h81, 4'd0, 0, 8'h81, 1, 0));
    vecs.push_back(mk(0, 1, 3'd7, 0, 0, 8'h00, 4'd3, 0, 8'h40, 0, 0));
    vecs.push_back(mk(0, 0, 3'd0, 0, 0, 8'h00, 4'd0, 1, 8'h20, 0, 0));
    vecs.push_back(mk(0, 0, 3'd0, 0, 0, 8'h00, 4'd0, 0, 8'h10, 1, 1));
    vecs.push_back(mk(0, 0, 3'd0, 0, 0, 8'h00, 4'd0, 0, 8'h10, 1, 0));
    vecs.push_back(mk(0, 1, 3'd7, 0, 0, 8'h00, 4'd0, 0, 8'h10, 1, 1));
    vecs.push_back(mk(0, 0, 3'd0, 0, 0, 8'h00, 4'd0, 0, 8'h10, 1, 0));
    vecs.push_back(mk(0, 1, 3'd7, 1, 0, 8'h00, 4'd4, 1, 8'h21, 0, 0));
    vecs.push_back(mk(0, 1, 3'd3, 1, 0, 8'hFF, 4'd0, 0, 8'h43, 0, 0));
    vecs.push_back(mk(0, 0, 3'd0, 0, 0, 8'h00, 4'd0, 0, 8'h86, 0, 0));
    vecs.push_back(mk(0, 0, 3'd0, 0, 0, 8'h00, 4'd0, 0, 8'h0C, 1, 1));
    vecs.push_back(mk(0, 1, 3'd3, 0, 0, 8'h3C, 4'd0, 0, 8'h3C, 1, 0));
    vecs.push_back(mk(0, 1, 3'd3, 0, 0, 8'hFF, 4'd0, 0, 8'hFF, 1, 0));
    vecs.push_back(mk(0, 1, 3'd7, 0, 1, 8'h00, 4'd5, 0, 8'hFF, 0, 0));
    vecs.push_back(mk(0, 0, 3'd0, 0, 1, 8'h00, 4'd0, 0, 8'hFF, 0, 0));
    vecs.push_back(mk(1, 0, 3'd0, 0, 1, 8'h00, 4'd0, 0, 8'h00, 1, 0));
    vecs.push_back(mk(0, 0, 3'd0, 0, 1, 8'h00, 4'd0, 0, 8'h00, 1, 0));
    vecs.push_back(mk(0, 1, 3'd3, 0, 0, 8'h01, 4'd0, 0, 8'h01, 1, 0));
    vecs.push_back(mk(0, 1, 3'd7, 0, 0, 8'h00, 4'd1, 1, 8'h02, 1, 1));
    vecs.push_back(mk(0, 0, 3'd0, 0, 0, 8'h00, 4'd0, 0, 8'h02, 1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
      ep = vecs[i].exp_p;
      check($sformatf("vec%0d p_dout", i), int'(bus_if.p_dout), int'(ep));
      check($sformatf("vec%0d op_ready", i), int'(bus_if.op_ready), int'(vecs[i].exp_ready));
      check($sformatf("vec%0d done", i), int'(bus_if.done), int'(vecs[i].exp_done));
      check($sformatf("vec%0d s_left_dout", i), int'(bus_if.s_left_dout), int'(ep[7]));
      check($sformatf("vec%0d s_right_dout", i), int'(bus_if.s_right_dout), int'(ep[0]));
    end

    for (int i = 0; i < 600; i++) begin
      v = mk(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0) ? 3'd7 : 3'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), 8'h00, 1'b0, 1'b0);
      apply(v);
      check($sformatf("rnd%0d p_dout", i), int'(bus_if.p_dout), m_p);
      check($sformatf("rnd%0d op_ready", i), int'(bus_if.op_ready), (m_pend == 0) ? 1 : 0);
      check($sformatf("rnd%0d done", i), int'(bus_if.done), m_done);
      check($sformatf("rnd%0d s_left_dout", i), int'(bus_if.s_left_dout), m_p / 128);
      check($sformatf("rnd%0d s_right_dout", i), int'(bus_if.s_right_dout), m_p % 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
